// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, fetches one word at a time over req/gnt + rvalid, and holds
// the fetched word in a 1-entry buffer (pc_if/inst_if/if_valid).
// Ports: clk, rst (sync, active-high); stall_in, redirect, redirect_pc from
// later stages; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata to memory;
// pc_if/inst_if/if_valid to IF/ID.
// Optional macro FETCH_MISALIGN_EN adds misalign_exc/misalign_pc and a HALT
// state entered on a misaligned redirect target.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_2003
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
`ifdef FETCH_MISALIGN_EN
   output logic        misalign_exc,
   output logic [31:0] misalign_pc,
`endif
   output logic [31:0] pc_if,
   output logic [31:0] inst_if,
   output logic        if_valid
);

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
`ifdef FETCH_MISALIGN_EN
   localparam logic [1:0] S_HALT  = 2'd3;
`endif

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_tgt;
   logic [31:0] inst_q;
   logic        valid_q;

`ifdef FETCH_MISALIGN_EN
   logic mis;
   logic halt_pend;

   assign mis    = (redirect_pc[1:0] != 2'b00);
   assign pc_tgt = redirect_pc;
`else
   // Low bits are forced to zero: targets are always word aligned.
   assign pc_tgt = redirect_pc & ~32'd3;
`endif

   // Request only when the buffer is free or drains at this edge; never
   // depends on the response side, so no rvalid -> req path exists.
   assign imem_req  = !rst && (state == S_REQ) && !redirect &&
                      (!valid_q || !stall_in);
   assign imem_addr = pc;
   assign if_valid  = valid_q;
   assign inst_if   = valid_q ? inst_q : NOP_INST;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_REQ:   if (imem_req && imem_gnt) state_nxt = S_WAIT;
         S_WAIT:  if (imem_rvalid) state_nxt = S_REQ;
`ifdef FETCH_MISALIGN_EN
         S_DRAIN: if (imem_rvalid) state_nxt = halt_pend ? S_HALT : S_REQ;
`else
         S_DRAIN: if (imem_rvalid) state_nxt = S_REQ;
`endif
         default: state_nxt = state;
      endcase
      if (redirect) begin
         // An outstanding response must still be swallowed in DRAIN.
         if ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid)
            state_nxt = S_DRAIN;
         else
            state_nxt = S_REQ;
`ifdef FETCH_MISALIGN_EN
         if (mis && state_nxt == S_REQ) state_nxt = S_HALT;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         pc_if   <= RESET_PC;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
         misalign_exc <= 1'b0;
         misalign_pc  <= 32'd0;
         halt_pend    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (redirect) begin
            pc      <= pc_tgt;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
`ifdef FETCH_MISALIGN_EN
            misalign_exc <= mis;
            halt_pend    <= mis;
            if (mis) misalign_pc <= redirect_pc;
`endif
         end else begin
            if (valid_q && !stall_in) valid_q <= 1'b0;
            if (state == S_WAIT && imem_rvalid) begin
               pc_if   <= pc;
               inst_q  <= imem_rdata;
               valid_q <= 1'b1;
               pc      <= pc + 32'd4;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch stimulus with a memory model, a
// program-order reference model and a queue-based scoreboard monitor.
module tb_if_fetch_unit;

   localparam logic [31:0] K      = 32'hA5A5_0000;
   localparam logic [31:0] NOP    = 32'h0000_2003;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_if;
   logic [31:0] inst_if;
   logic        if_valid;
`ifdef FETCH_MISALIGN_EN
   logic        misalign_exc;
   logic [31:0] misalign_pc;
`endif

   if_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall_in    (stall_in),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
`ifdef FETCH_MISALIGN_EN
      .misalign_exc(misalign_exc),
      .misalign_pc (misalign_pc),
`endif
      .pc_if       (pc_if),
      .inst_if     (inst_if),
      .if_valid    (if_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [63:0] sb[$];

   logic [31:0] model_pc;
   logic [31:0] exp_fetch;
   logic [31:0] paddr;
   logic [31:0] hold_addr;
   bit          pend;
   bit          drop;
   bit          exp_valid;
   bit          halted;
   bit          holding;
   int          cnt;
   bit          exp_exc;
   logic [31:0] exp_mpc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout", nm);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (if_valid && !redirect) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual=%h required=none",
                        pc_if);
            end else begin
               chk("pc_if", pc_if, sb[0][63:32]);
               chk("inst_if", inst_if, sb[0][31:0]);
               if (!stall_in) void'(sb.pop_front());
            end
         end else if (!if_valid) begin
            chk("inst_nop", inst_if, NOP);
         end
      end
   end

   task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc,
                        input int gpct, input int lat);
      bit rv;
      bit drop_was;
      bit keep;
      bit mis_rd;
      bit busy;
      logic [31:0] tgt;
      @(posedge clk);
      #1;
      rv = pend && (cnt == 0);
      if (rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = paddr ^ K;
         pend = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend) cnt--;
      end
      imem_gnt    = ($urandom_range(99) < gpct);
      stall_in    = st;
      redirect    = rd;
      redirect_pc = rd ? rpc : $urandom;
      drop_was = drop;
      if (rv) drop = 1'b0;
      keep = rv && !drop_was && !rd;
      busy = pend || rv;
      mis_rd = 1'b0;
      if (rd) begin
`ifdef FETCH_MISALIGN_EN
         mis_rd = (rpc[1:0] != 2'b00);
         tgt = rpc;
`else
         tgt = {rpc[31:2], 2'b00};
`endif
         if (pend) drop = 1'b1;
         sb.delete();
         model_pc  = tgt;
         exp_fetch = tgt;
      end
      #1;
      chk("imem_req", 32'(imem_req),
          32'(!rd && !busy && !halted && !(exp_valid && st)));
      chk("if_valid", 32'(if_valid), 32'(exp_valid));
      if (holding && imem_req) chk("addr_hold", imem_addr, hold_addr);
      holding   = imem_req && !imem_gnt;
      hold_addr = imem_addr;
      if (imem_req && imem_gnt) begin
         chk("imem_addr", imem_addr, exp_fetch);
         exp_fetch = exp_fetch + 32'd4;
         pend  = 1'b1;
         paddr = imem_addr;
         cnt   = lat - 1;
      end
      if (keep) begin
         sb.push_back({model_pc, model_pc ^ K});
         model_pc = model_pc + 32'd4;
      end
      exp_valid = rd ? 1'b0 : (keep ? 1'b1 : (exp_valid && st));
`ifdef FETCH_MISALIGN_EN
      chk("misalign_exc", 32'(misalign_exc), 32'(exp_exc));
      if (exp_exc) chk("misalign_pc", misalign_pc, exp_mpc);
      if (rd) begin
         exp_exc = mis_rd;
         if (mis_rd) exp_mpc = rpc;
      end
`endif
      if (rd) halted = mis_rd;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      stall_in = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'd0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'd0;
      pend = 1'b0; drop = 1'b0; exp_valid = 1'b0; halted = 1'b0;
      holding = 1'b0; cnt = 0; exp_exc = 1'b0; exp_mpc = 32'd0;
      paddr = 32'd0; hold_addr = 32'd0;
      model_pc = RST_PC;
      exp_fetch = RST_PC;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_inst", inst_if, NOP);
      chk("rst_pc_if", pc_if, RST_PC);
`ifdef FETCH_MISALIGN_EN
      chk("rst_exc", 32'(misalign_exc), 32'd0);
      chk("rst_mpc", misalign_pc, 32'd0);
`endif
      rst = 1'b0;
      mon_en = 1'b1;

      // streaming with a 1-cycle memory
      repeat (12) cycle(1'b0, 1'b0, 32'd0, 100, 1);

      // stall while the buffer is full
      n = 0;
      while (!exp_valid && n < 20) begin
         cycle(1'b0, 1'b0, 32'd0, 100, 1);
         n++;
      end
      if (!exp_valid) timeout("stall_setup");
      repeat (5) cycle(1'b1, 1'b0, 32'd0, 100, 1);
      repeat (6) cycle(1'b0, 1'b0, 32'd0, 100, 1);

      // redirect one cycle after a grant with a 3-cycle memory
      n = 0;
      while (!(pend && cnt == 2) && n < 20) begin
         cycle(1'b0, 1'b0, 32'd0, 100, 3);
         n++;
      end
      if (!(pend && cnt == 2)) timeout("drain_setup");
      cycle(1'b0, 1'b1, 32'h0000_0100, 100, 3);
      repeat (12) cycle(1'b0, 1'b0, 32'd0, 100, 3);

      // redirect in the same cycle as rvalid
      n = 0;
      while (!(pend && cnt == 0) && n < 20) begin
         cycle(1'b0, 1'b0, 32'd0, 100, 1);
         n++;
      end
      if (!(pend && cnt == 0)) timeout("rv_redirect_setup");
      cycle(1'b0, 1'b1, 32'h0000_0200, 100, 1);
      repeat (6) cycle(1'b0, 1'b0, 32'd0, 100, 1);

      // grant withheld
      repeat (6) cycle(1'b0, 1'b0, 32'd0, 0, 1);
      repeat (4) cycle(1'b0, 1'b0, 32'd0, 100, 1);

      // wrap at the top of the address space
      cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 100, 1);
      repeat (12) cycle(1'b0, 1'b0, 32'd0, 100, 1);

`ifdef FETCH_MISALIGN_EN
      cycle(1'b0, 1'b1, 32'h0000_0102, 100, 1);
      repeat (6) cycle(1'b0, 1'b0, 32'd0, 100, 1);
      cycle(1'b0, 1'b1, 32'h0000_0200, 100, 1);
      repeat (8) cycle(1'b0, 1'b0, 32'd0, 100, 1);
`endif

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] r;
         r = $urandom;
         if ($urandom_range(7) == 0) r = 32'hFFFF_FFE0 | (r & 32'h1F);
         cycle(($urandom_range(3) == 0), ($urandom_range(11) == 0), r,
               70, int'($urandom_range(4, 1)));
      end
      repeat (10) cycle(1'b0, 1'b0, 32'd0, 100, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
